// File: rtl/sa_wrr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin address-channel arbiter:
// state encoding, default credit width and per-master weight extraction.
package sa_arb_pkg;

    localparam int CREDIT_W_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Keep only the low credit_w bits of a weight word; a zero weight still earns one transfer.
    function automatic logic [31:0] eff_weight(input logic [31:0] word, input int credit_w);
        logic [31:0] mask;
        logic [31:0] w;
        mask = (credit_w >= 32) ? '1 : ((32'd1 << credit_w) - 32'd1);
        w    = word & mask;
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/sa_wrr_arbiter_if.sv
// Request/grant bundle between the dispatchers' address channel and the arbiter.
interface sa_wrr_arbiter_if
    import sa_arb_pkg::*;
#(
    parameter int MST_AMT  = 4,
    parameter int CREDIT_W = CREDIT_W_DEF,
    parameter int MST_ID_W = $clog2(MST_AMT)
);

    logic [MST_AMT-1:0]  req_i;
    logic [MST_AMT-1:0]  mst_full_i;
    logic                stall_i;
    logic                ack_i;
    logic [MST_AMT-1:0]  grant_o;
    logic [MST_ID_W-1:0] grant_id_o;
    logic                grant_valid_o;
    logic [CREDIT_W-1:0] credit_o;

    modport slave (
        input  req_i, mst_full_i, stall_i, ack_i,
        output grant_o, grant_id_o, grant_valid_o, credit_o
    );

    modport master (
        output req_i, mst_full_i, stall_i, ack_i,
        input  grant_o, grant_id_o, grant_valid_o, credit_o
    );

endinterface

// File: rtl/sa_wrr_arbiter_picker.sv
// Rotating-priority encoder: first set bit of elig_i scanning ptr_i, ptr_i+1, ... (mod MST_AMT).
module sa_rr_picker #(
    parameter int MST_AMT  = 4,
    parameter int MST_ID_W = $clog2(MST_AMT)
) (
    input  logic [MST_AMT-1:0]  elig_i,
    input  logic [MST_ID_W-1:0] ptr_i,
    output logic                found_o,
    output logic [MST_AMT-1:0]  pick_oh_o,
    output logic [MST_ID_W-1:0] pick_id_o
);

    always_comb begin
        int                  idx;
        logic [MST_ID_W-1:0] idx_w;
        found_o   = 1'b0;
        pick_oh_o = '0;
        pick_id_o = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < MST_AMT; k++) begin
            idx   = (int'(ptr_i) + k) % MST_AMT;
            idx_w = MST_ID_W'(idx);
            if (!found_o && elig_i[idx_w]) begin
                found_o          = 1'b1;
                pick_oh_o[idx_w] = 1'b1;
                pick_id_o        = idx_w;
            end
        end
    end

endmodule

// File: rtl/sa_wrr_arbiter.sv
// Weighted round-robin grant sequencer for one slave address channel; each master
// keeps the grant for up to its weight in accepted transfers before rotation.
module sa_wrr_arbiter
    import sa_arb_pkg::*;
#(
    parameter int                       MST_AMT    = 4,
    parameter logic [0:MST_AMT*32-1]    MST_WEIGHT = {32'd5, 32'd3, 32'd2, 32'd1},
    parameter int                       MST_ID_W   = $clog2(MST_AMT),
    parameter int                       CREDIT_W   = CREDIT_W_DEF
) (
    input  logic             ACLK_i,
    input  logic             ARESETn_i,
    sa_wrr_arbiter_if.slave  arb_if
);

    arb_state_e          state_q, state_d;
    logic [MST_ID_W-1:0] ptr_q, ptr_d;
    logic [MST_AMT-1:0]  grant_q, grant_d;
    logic [MST_ID_W-1:0] gid_q, gid_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;

    logic [CREDIT_W-1:0] weight [MST_AMT];
    logic [MST_AMT-1:0]  elig;
    logic [MST_ID_W-1:0] next_id;
    logic [MST_ID_W-1:0] pick_ptr;
    logic                found;
    logic [MST_AMT-1:0]  pick_oh;
    logic [MST_ID_W-1:0] pick_id;
    logic [CREDIT_W-1:0] credit_dec;

    // Master 0 owns the most significant weight word.
    for (genvar i = 0; i < MST_AMT; i++) begin : g_weight
        localparam logic [31:0] WFULL = eff_weight(MST_WEIGHT[i*32 +: 32], CREDIT_W);
        assign weight[i] = WFULL[CREDIT_W-1:0];
    end

    assign elig       = arb_if.req_i & ~arb_if.mst_full_i;
    assign next_id    = (gid_q == MST_ID_W'(MST_AMT - 1)) ? '0 : gid_q + 1'b1;
    assign credit_dec = credit_q - CREDIT_W'(1);

    // While granted, the only re-pick happens after the current master, so scan from g+1.
    assign pick_ptr = (state_q == ST_GRANT) ? next_id : ptr_q;

    sa_rr_picker #(
        .MST_AMT  (MST_AMT),
        .MST_ID_W (MST_ID_W)
    ) u_picker (
        .elig_i    (elig),
        .ptr_i     (pick_ptr),
        .found_o   (found),
        .pick_oh_o (pick_oh),
        .pick_id_o (pick_id)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        gid_d    = gid_q;
        credit_d = credit_q;
        case (state_q)
            ST_IDLE: begin
                if (found && !arb_if.stall_i) begin
                    state_d  = ST_GRANT;
                    grant_d  = pick_oh;
                    gid_d    = pick_id;
                    credit_d = weight[pick_id];
                end
            end
            ST_GRANT: begin
                if (arb_if.ack_i) begin
                    if ((credit_dec != '0) && elig[gid_q] && !arb_if.stall_i) begin
                        credit_d = credit_dec;
                    end else begin
                        ptr_d = next_id;
                        if (found && !arb_if.stall_i) begin
                            grant_d  = pick_oh;
                            gid_d    = pick_id;
                            credit_d = weight[pick_id];
                        end else begin
                            state_d  = ST_IDLE;
                            grant_d  = '0;
                            gid_d    = '0;
                            credit_d = '0;
                        end
                    end
                end else if (!arb_if.req_i[gid_q]) begin
                    // Requester dropped VALID without a handshake: release, keep pointer and credits unspent.
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    gid_d    = '0;
                    credit_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            gid_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            credit_q <= credit_d;
        end
    end

    assign arb_if.grant_o       = grant_q;
    assign arb_if.grant_id_o    = gid_q;
    assign arb_if.grant_valid_o = (state_q == ST_GRANT);
    assign arb_if.credit_o      = credit_q;

endmodule
